// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci generator and its downstream output buffer.
package fib_pkg;

    localparam int unsigned FIB_W = 16;

    typedef logic [FIB_W-1:0] fib_word_t;

    typedef struct packed {
        logic      last;
        fib_word_t data;
    } fib_entry_t;

endpackage

// File: rtl/fib_out_buffer_if.sv
// Term capture and valid/ready output handshake between generator, buffer and consumer.
interface fib_out_buffer_if;
    import fib_pkg::*;

    logic      in_valid;
    fib_word_t in_data;
    logic      in_last;
    logic      out_valid;
    logic      out_ready;
    fib_word_t out_data;
    logic      out_last;

    // Buffer side: takes generator terms, offers queued entries downstream.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    // Environment side: generator producing terms plus the consuming stage.
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/fib_seq_checker.sv
// Verifies each term equals the sum of the previous two within one run; sticky error flag.
module fib_seq_checker #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              seq_err
);

    logic [DATA_W-1:0] r_p1;
    logic [DATA_W-1:0] r_p2;
    logic [1:0]        r_idx;
    logic              r_err;
    logic [DATA_W-1:0] w_sum;

    assign w_sum   = r_p1 + r_p2;
    assign seq_err = r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_p1  <= '0;
            r_p2  <= '0;
            r_idx <= '0;
            r_err <= 1'b0;
        end else if (in_valid) begin
            if (r_idx == 2'd2 && in_data != w_sum) begin
                r_err <= 1'b1;
            end
            // The framed term is checked first; history then restarts at index 0.
            if (in_last) begin
                r_p1  <= '0;
                r_p2  <= '0;
                r_idx <= '0;
            end else begin
                r_p2 <= r_p1;
                r_p1 <= in_data;
                if (r_idx != 2'd2) begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fib_out_buffer.sv
// First-word-fall-through FIFO for Fibonacci terms with run framing and sticky overflow.
// Define FIB_OUT_BUFFER_SEQ_CHECK_EN to add the arithmetic sequence checker (seq_err).
module fib_out_buffer
    import fib_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = FIB_W
) (
    input  logic                   clk,
    input  logic                   reset,
    fib_out_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   seq_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fib_entry_t        r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_in_data;

    assign w_in_data = bus.in_data;
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    // Fullness is judged before this cycle's pop, so a same-cycle pop cannot rescue a term.
    assign w_push    = bus.in_valid && !w_full;
    assign w_pop     = !w_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= '{last: bus.in_last, data: w_in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (bus.in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = r_mem[r_rd_ptr].data;
    assign bus.out_last  = r_mem[r_rd_ptr].last;
    assign count         = r_count;
    assign overflow      = r_overflow;

`ifdef FIB_OUT_BUFFER_SEQ_CHECK_EN
    fib_seq_checker #(
        .DATA_W (DATA_W)
    ) u_seq_checker (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.in_valid),
        .in_data  (w_in_data),
        .in_last  (bus.in_last),
        .seq_err  (seq_err)
    );
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_out_buffer.sv
// Directed self-checking bench for fib_out_buffer (DEPTH=8).
module tb_fib_out_buffer;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic       overflow;
    logic       seq_err;

    int unsigned n_pass;
    int unsigned n_total;

    fib_out_buffer_if bus ();

    fib_out_buffer #(
        .DEPTH  (8),
        .DATA_W (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .overflow (overflow),
        .seq_err  (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [15:0] fib8 [8];
    logic [15:0] seq6 [6];
    logic [15:0] frm_d [5];
    logic        frm_l [5];

    initial begin
        n_pass  = 0;
        n_total = 0;
        fib8  = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
        seq6  = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5};
        frm_d = '{16'd0, 16'd1, 16'd1, 16'd0, 16'd1};
        frm_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset for two cycles with a term presented that must be discarded.
        reset         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'd7;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count",     32'(count),         32'd0);
        chk("rst_overflow",  32'(overflow),      32'd0);
        chk("rst_seq_err",   32'(seq_err),       32'd0);

        // Pop request on an empty FIFO does nothing.
        bus.out_ready = 1'b1;
        tick();
        chk("empty_pop_count", 32'(count),         32'd0);
        chk("empty_pop_valid", 32'(bus.out_valid), 32'd0);

        // Ordered pass-through, each term visible one cycle after its push.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = seq6[i];
            tick();
            chk("pt_valid", 32'(bus.out_valid), 32'd1);
            chk("pt_data",  32'(bus.out_data),  32'(seq6[i]));
            chk("pt_count", 32'(count),         32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("pt_drained", 32'(count),   32'd0);
        chk("pt_seq_err", 32'(seq_err), 32'd0);

        // Backpressure fill, overflow, then drain.
        pulse_reset();
        for (int i = 0; i < 8; i++) push(fib8[i], 1'b0);
        chk("bp_count_full", 32'(count),        32'd8);
        chk("bp_head_stable", 32'(bus.out_data), 32'd0);
        chk("bp_no_ovf_yet", 32'(overflow),     32'd0);
        push(16'd21, 1'b0);
        chk("bp_overflow",   32'(overflow),     32'd1);
        chk("bp_count_held", 32'(count),        32'd8);
        chk("bp_head_held",  32'(bus.out_data), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_drain_data",  32'(bus.out_data),  32'(fib8[i]));
            tick();
        end
        chk("bp_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_empty_count", 32'(count),         32'd0);
        chk("bp_ovf_sticky",  32'(overflow),      32'd1);
        chk("bp_seq_err",     32'(seq_err),       32'd0);

        // Full FIFO: push and pop in the same cycle; the push is still dropped.
        pulse_reset();
        chk("rst_clears_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) push(fib8[i], 1'b0);
        chk("fp_count_full", 32'(count), 32'd8);
        bus.out_ready = 1'b1;
        push(16'd21, 1'b0);
        chk("fp_overflow", 32'(overflow),     32'd1);
        chk("fp_count",    32'(count),        32'd7);
        for (int i = 1; i < 8; i++) begin
            chk("fp_drain_data", 32'(bus.out_data), 32'(fib8[i]));
            tick();
        end
        chk("fp_empty", 32'(bus.out_valid), 32'd0);

        // Framing: last marker travels with the third term; checker restarts after it.
        pulse_reset();
        for (int i = 0; i < 5; i++) push(frm_d[i], frm_l[i]);
        chk("fr_count", 32'(count), 32'd5);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("fr_data", 32'(bus.out_data), 32'(frm_d[i]));
            chk("fr_last", 32'(bus.out_last), 32'(frm_l[i]));
            tick();
        end
        chk("fr_seq_err", 32'(seq_err), 32'd0);

        // Arithmetic error: 0,1,1,3.
        pulse_reset();
        bus.out_ready = 1'b1;
        push(16'd0, 1'b0);
        push(16'd1, 1'b0);
        push(16'd1, 1'b0);
        chk("se_before", 32'(seq_err), 32'd0);
        push(16'd3, 1'b0);
`ifdef FIB_OUT_BUFFER_SEQ_CHECK_EN
        chk("se_flag", 32'(seq_err), 32'd1);
`else
        chk("se_tied_low", 32'(seq_err), 32'd0);
`endif
        chk("se_data", 32'(bus.out_data), 32'd3);
        pulse_reset();
        chk("se_rst_clear", 32'(seq_err), 32'd0);
        chk("se_rst_count", 32'(count),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fib_out_buffer.md
Name: fib_out_buffer

Overview:
- Downstream consumer of the Fibonacci generator (`fibo`).
- Captures each 16-bit term the generator produces on its `enable` strobe, queues the terms in a small FIFO, and presents them to the next stage over a valid/ready handshake.
- Marks the term that coincided with the generator's `done`, so downstream logic can frame one sequence run.
- Flags overflow and, optionally, arithmetic sequence errors.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- DATA_W, 16, term width; must match the generator's `fib_out`.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- in_valid  input  1  one-cycle strobe: `in_data`/`in_last` are a new term (driven from the generator's `enable`).
- in_data  input  DATA_W  term from the generator's `fib_out`.
- in_last  input  1  generator's `done`, sampled with `in_valid`.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  DATA_W  head entry data.
- out_last  output  1  head entry was captured with `in_last=1`.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a term was dropped.
- seq_err  output  1  sticky: sequence check failed (see optional feature).

Behaviour:
- Reset (reset==0 at a clk edge):
  - rd_ptr, wr_ptr and count go to 0.
  - out_valid, overflow and seq_err go to 0.
  - Checker history is cleared.
  - FIFO memory contents are don't-care.
  - Reset overrides all other activity, including mid-transfer; a term presented in the reset cycle is discarded.
- Push:
  - Occurs when in_valid && !full, where full means count==DEPTH evaluated before this cycle's pop.
  - Writes {in_last, in_data} to mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
- Drop:
  - in_valid while full: the term is discarded, overflow sets to 1, and FIFO state is unchanged.
  - A same-cycle pop does not rescue the term.
- Pop:
  - Occurs when out_valid && out_ready; rd_ptr wraps modulo DEPTH.
  - out_ready while empty has no effect.
- Simultaneous push and pop (non-full, non-empty): count is unchanged and both pointers advance.
- Output path:
  - First-word-fall-through: out_data/out_last come combinationally from mem[rd_ptr].
  - out_valid = (count != 0).
  - A term pushed into an empty FIFO appears on the outputs in the cycle after the push edge (1-cycle latency).
  - out_data/out_last must stay stable while out_valid && !out_ready.
- count: registered; increments by 1 on push only, decrements by 1 on pop only.
- Sticky flags: overflow and seq_err clear only on reset.

Optional Feature:
- Macro: FIB_OUT_BUFFER_SEQ_CHECK_EN.
- Defined — checker state:
  - Tracks p1 (last term), p2 (the term before) and a 2-bit term index per run, updated on every in_valid, whether or not the term is dropped.
  - For index>=2, if in_data != (p1+p2) mod 2^DATA_W, seq_err sets to 1.
  - Index saturates at 2.
- Defined — run boundary:
  - An in_valid carrying in_last=1 is checked, then the history clears.
  - The next term is therefore index 0.
- Not defined: seq_err is tied to 0 and no checker registers are instantiated.

Decomposition:
- Shared package fib_pkg holds:
  - FIB_W = 16.
  - typedef fib_word_t (logic [FIB_W-1:0]).
  - typedef fib_entry_t struct {last, data}.
- One natural sub-module: fib_seq_checker, holding p1/p2/index/seq_err.
  - Instantiated only under FIB_OUT_BUFFER_SEQ_CHECK_EN.
- FIFO storage and pointers live in the top module.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release → out_valid=0, count=0, overflow=0, seq_err=0.
- Ordered pass-through: push 0,1,1,2,3,5 with out_ready=1 → out_data sequence 0,1,1,2,3,5, each one cycle after its push; seq_err=0.
- Backpressure and overflow (out_ready=0, DEPTH=8):
  - Push 0,1,1,2,3,5,8,13 → count=8.
  - Push 21 → overflow=1, count stays 8.
  - Raise out_ready → drain returns 0..13; 21 is absent.
- Full with simultaneous pop: count=8, in_valid with 21 and out_ready=1 in the same cycle → 21 dropped, overflow=1, count=7.
- Framing:
  - Push 0,1,1 with in_last=1 on the third term, then 0,1 → out_last=1 only on the third output.
  - Checker restarts after the framed term: no seq_err on the second 0.
- Sequence error (macro defined): push 0,1,1,3 → seq_err=1 the cycle after the 3 is presented. Pulse reset → seq_err=0.
